// File: rtl/anti_theft_pkg.sv
// Shared constants for the vehicle alarm controller: state codes, interval
// parameter indices and the power-on interval values (seconds).
package anti_theft_pkg;

  localparam logic [2:0] S_DISARMED   = 3'd0;
  localparam logic [2:0] S_WAIT_OPEN  = 3'd1;
  localparam logic [2:0] S_WAIT_CLOSE = 3'd2;
  localparam logic [2:0] S_ARM_DELAY  = 3'd3;
  localparam logic [2:0] S_ARMED      = 3'd4;
  localparam logic [2:0] S_TRIGGERED  = 3'd5;
  localparam logic [2:0] S_ALARM      = 3'd6;
  localparam logic [2:0] S_ALARM_HOLD = 3'd7;

  localparam logic [1:0] SEL_ARM_DELAY = 2'b00;
  localparam logic [1:0] SEL_DRIVER    = 2'b01;
  localparam logic [1:0] SEL_PASSENGER = 2'b10;
  localparam logic [1:0] SEL_ALARM_ON  = 2'b11;

  localparam logic [3:0] T_ARM_DELAY_DEF     = 4'd6;
  localparam logic [3:0] T_DRIVER_DELAY_DEF  = 4'd8;
  localparam logic [3:0] T_PASSENGER_DEF     = 4'd15;
  localparam logic [3:0] T_ALARM_ON_DEF      = 4'd10;

  // States in which the external timer is counting an interval.
  function automatic logic is_timed_state(input logic [2:0] state);
    return (state == S_ARM_DELAY) || (state == S_TRIGGERED) ||
           (state == S_ALARM_HOLD);
  endfunction

endpackage

// File: rtl/fuel_pump_lock.sv
// Fuel-pump immobiliser: the pump is enabled only once, with ignition on,
// the hidden switch and the brake are pressed together; ignition off re-locks.
module fuel_pump_lock (
  input  logic clock,
  input  logic reset,
  input  logic ignition,
  input  logic hidden_sw,
  input  logic brake,
  output logic fuel_pump
);

  logic r_unlocked;

  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      r_unlocked <= 1'b0;
    end else if (!ignition) begin
      r_unlocked <= 1'b0;
    end else if (hidden_sw && brake) begin
      r_unlocked <= 1'b1;
    end
  end

  assign fuel_pump = r_unlocked;

endmodule

// File: rtl/alarm_controller.sv
// Vehicle anti-theft alarm FSM driving an external interval timer.
// Define FUEL_PUMP_LOCK_EN to gate the fuel pump behind hidden_sw + brake.
module alarm_controller
  import anti_theft_pkg::*;
(
  input  logic       clock,
  input  logic       reset,
  input  logic       ignition,
  input  logic       door_driver,
  input  logic       door_pass,
  input  logic       hidden_sw,
  input  logic       brake,
  input  logic       reprogram,
  input  logic [1:0] time_param_sel,
  input  logic [3:0] time_value,
  input  logic       one_hz_enable,
  input  logic       two_hz_enable,
  input  logic       expired,
  output logic       start_timer,
  output logic [3:0] value,
  output logic       siren,
  output logic       status_led,
  output logic       fuel_pump,
  output logic [2:0] state_dbg
);

  logic [2:0] r_state;
  logic [2:0] w_state_next;
  logic [1:0] r_sel;
  logic [1:0] w_sel_next;
  logic [3:0] r_params [4];
  logic       r_start_timer;
  logic       r_timer_live;
  logic       r_siren;
  logic       r_status_led;
  logic       w_door_open;
  logic       w_expired_ok;
  logic       w_state_hold;
  logic       w_unused_tick;

  // The timer's own 1 Hz tick is only consumed by the timer itself.
  assign w_unused_tick = one_hz_enable;

  assign w_door_open  = door_driver | door_pass;
  // Expiry counts only once start_timer has been high for a full cycle,
  // so a stale expiry from a previous interval is never honoured.
  assign w_expired_ok = expired & r_start_timer & r_timer_live;

  always_comb begin
    w_state_next = r_state;
    w_sel_next   = r_sel;
    if (ignition) begin
      w_state_next = S_DISARMED;
    end else if (reprogram) begin
      w_state_next = S_ARMED;
      w_sel_next   = time_param_sel;
    end else begin
      case (r_state)
        S_DISARMED: begin
          w_state_next = S_WAIT_OPEN;
        end
        S_WAIT_OPEN: begin
          if (door_driver) begin
            w_state_next = S_WAIT_CLOSE;
          end
        end
        S_WAIT_CLOSE: begin
          if (!w_door_open) begin
            w_state_next = S_ARM_DELAY;
            w_sel_next   = SEL_ARM_DELAY;
          end
        end
        S_ARM_DELAY: begin
          if (w_door_open) begin
            w_state_next = S_WAIT_CLOSE;
          end else if (w_expired_ok) begin
            w_state_next = S_ARMED;
          end
        end
        S_ARMED: begin
          if (w_door_open) begin
            w_state_next = S_TRIGGERED;
            w_sel_next   = door_driver ? SEL_DRIVER : SEL_PASSENGER;
          end
        end
        S_TRIGGERED: begin
          if (w_expired_ok) begin
            w_state_next = S_ALARM;
          end
        end
        S_ALARM: begin
          if (!w_door_open) begin
            w_state_next = S_ALARM_HOLD;
            w_sel_next   = SEL_ALARM_ON;
          end
        end
        S_ALARM_HOLD: begin
          if (w_door_open) begin
            w_state_next = S_ALARM;
          end else if (w_expired_ok) begin
            w_state_next = S_ARMED;
          end
        end
        default: begin
          w_state_next = S_ARMED;
        end
      endcase
    end
  end

  assign w_state_hold = (w_state_next == r_state);

  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      r_state       <= S_ARMED;
      r_sel         <= SEL_ARM_DELAY;
      r_params[0]   <= T_ARM_DELAY_DEF;
      r_params[1]   <= T_DRIVER_DELAY_DEF;
      r_params[2]   <= T_PASSENGER_DEF;
      r_params[3]   <= T_ALARM_ON_DEF;
      r_start_timer <= 1'b0;
      r_timer_live  <= 1'b0;
      r_siren       <= 1'b0;
      r_status_led  <= 1'b0;
    end else begin
      r_state <= w_state_next;
      r_sel   <= w_sel_next;
      if (reprogram) begin
        r_params[time_param_sel] <= time_value;
      end
      // Drops on the edge that changes state, so every entry sees a low cycle.
      r_start_timer <= is_timed_state(r_state) & w_state_hold;
      r_timer_live  <= r_start_timer;
      r_siren       <= (r_state == S_ALARM) || (r_state == S_ALARM_HOLD);
      if (r_state == S_ARMED) begin
        r_status_led <= two_hz_enable ? ~r_status_led : r_status_led;
      end else begin
        r_status_led <= (r_state == S_TRIGGERED) || (r_state == S_ALARM) ||
                        (r_state == S_ALARM_HOLD);
      end
    end
  end

`ifdef FUEL_PUMP_LOCK_EN
  fuel_pump_lock u_fuel_pump_lock (
    .clock     (clock),
    .reset     (reset),
    .ignition  (ignition),
    .hidden_sw (hidden_sw),
    .brake     (brake),
    .fuel_pump (fuel_pump)
  );
`else
  logic r_fuel_pump;
  logic w_unused_lock_inputs;

  assign w_unused_lock_inputs = hidden_sw & brake;

  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      r_fuel_pump <= 1'b0;
    end else begin
      r_fuel_pump <= ignition;
    end
  end

  assign fuel_pump = r_fuel_pump;
`endif

  assign start_timer = r_start_timer;
  assign value       = r_params[r_sel];
  assign siren       = r_siren;
  assign status_led  = r_status_led;
  assign state_dbg   = r_state;

endmodule

// File: tb/tb_alarm_controller.sv
// Directed-vector bench for alarm_controller; the external timer is driven
// by hand so each interval and expiry lands on a known cycle.
module tb_alarm_controller;

  logic       clock = 1'b0;
  logic       reset;
  logic       ignition, door_driver, door_pass, hidden_sw, brake;
  logic       reprogram;
  logic [1:0] time_param_sel;
  logic [3:0] time_value;
  logic       one_hz_enable, two_hz_enable, expired;
  logic       start_timer;
  logic [3:0] value;
  logic       siren, status_led, fuel_pump;
  logic [2:0] state_dbg;

  int n_checks   = 0;
  int n_failures = 0;

  localparam logic [7:0] ST_DISARMED   = 8'd0;
  localparam logic [7:0] ST_WAIT_OPEN  = 8'd1;
  localparam logic [7:0] ST_WAIT_CLOSE = 8'd2;
  localparam logic [7:0] ST_ARM_DELAY  = 8'd3;
  localparam logic [7:0] ST_ARMED      = 8'd4;
  localparam logic [7:0] ST_TRIGGERED  = 8'd5;
  localparam logic [7:0] ST_ALARM      = 8'd6;
  localparam logic [7:0] ST_ALARM_HOLD = 8'd7;

  alarm_controller dut (
    .clock          (clock),
    .reset          (reset),
    .ignition       (ignition),
    .door_driver    (door_driver),
    .door_pass      (door_pass),
    .hidden_sw      (hidden_sw),
    .brake          (brake),
    .reprogram      (reprogram),
    .time_param_sel (time_param_sel),
    .time_value     (time_value),
    .one_hz_enable  (one_hz_enable),
    .two_hz_enable  (two_hz_enable),
    .expired        (expired),
    .start_timer    (start_timer),
    .value          (value),
    .siren          (siren),
    .status_led     (status_led),
    .fuel_pump      (fuel_pump),
    .state_dbg      (state_dbg)
  );

  always #5 clock = ~clock;

  task automatic check_eq(input string tag, input logic [7:0] obs,
                          input logic [7:0] exp);
    n_checks++;
    if (obs !== exp) begin
      n_failures++;
      $display("FAIL %s: got %0d expected %0d", tag, obs, exp);
    end else begin
      $display("ok   %s = %0d", tag, obs);
    end
  endtask

  task automatic tick();
    @(posedge clock);
    #1;
  endtask

  initial begin
    reset = 1'b1;
    ignition = 0; door_driver = 0; door_pass = 0; hidden_sw = 0; brake = 0;
    reprogram = 0; time_param_sel = 2'b00; time_value = 4'd0;
    one_hz_enable = 0; two_hz_enable = 0; expired = 0;
    tick();
    tick();
    check_eq("reset_state", {5'd0, state_dbg}, ST_ARMED);
    check_eq("reset_start_timer", {7'd0, start_timer}, 8'd0);
    check_eq("reset_siren", {7'd0, siren}, 8'd0);
    check_eq("reset_status_led", {7'd0, status_led}, 8'd0);
    check_eq("reset_fuel_pump", {7'd0, fuel_pump}, 8'd0);
    check_eq("reset_value_arm_delay", {4'd0, value}, 8'd6);
    reset = 1'b0;
    tick();

    // Driver door opens while armed: driver interval, then full alarm.
    door_driver = 1;
    tick();
    door_driver = 0;
    check_eq("drv_state", {5'd0, state_dbg}, ST_TRIGGERED);
    check_eq("drv_value", {4'd0, value}, 8'd8);
    check_eq("drv_start_entry_low", {7'd0, start_timer}, 8'd0);
    tick();
    check_eq("drv_start_rises", {7'd0, start_timer}, 8'd1);
    check_eq("drv_led_steady", {7'd0, status_led}, 8'd1);
    for (int i = 0; i < 8; i++) begin
      one_hz_enable = 1;
      tick();
      one_hz_enable = 0;
    end
    check_eq("drv_still_triggered", {5'd0, state_dbg}, ST_TRIGGERED);
    expired = 1;
    tick();
    expired = 0;
    check_eq("drv_alarm", {5'd0, state_dbg}, ST_ALARM);
    tick();
    check_eq("drv_siren", {7'd0, siren}, 8'd1);
    check_eq("drv_hold", {5'd0, state_dbg}, ST_ALARM_HOLD);
    check_eq("hold_value", {4'd0, value}, 8'd10);

    // Door reopens halfway through the alarm-on interval.
    tick();
    check_eq("hold_start", {7'd0, start_timer}, 8'd1);
    for (int i = 0; i < 5; i++) begin
      one_hz_enable = 1;
      tick();
      one_hz_enable = 0;
    end
    door_pass = 1;
    tick();
    check_eq("reopen_state", {5'd0, state_dbg}, ST_ALARM);
    check_eq("reopen_start_low", {7'd0, start_timer}, 8'd0);
    check_eq("reopen_siren", {7'd0, siren}, 8'd1);
    tick();
    check_eq("open_alarm_start_idle", {7'd0, start_timer}, 8'd0);
    check_eq("open_alarm_siren", {7'd0, siren}, 8'd1);
    door_pass = 0;
    tick();
    check_eq("reclose_hold", {5'd0, state_dbg}, ST_ALARM_HOLD);
    tick();
    check_eq("reclose_start", {7'd0, start_timer}, 8'd1);

    // Reset mid-interval with expiry asserted: countdown abandoned.
    expired = 1;
    reset = 1;
    tick();
    check_eq("midreset_state", {5'd0, state_dbg}, ST_ARMED);
    check_eq("midreset_start", {7'd0, start_timer}, 8'd0);
    check_eq("midreset_siren", {7'd0, siren}, 8'd0);
    reset = 0;
    tick();
    expired = 0;
    check_eq("postreset_state", {5'd0, state_dbg}, ST_ARMED);

    // Both doors at once: driver interval wins.
    door_driver = 1;
    door_pass = 1;
    tick();
    door_driver = 0;
    door_pass = 0;
    check_eq("both_state", {5'd0, state_dbg}, ST_TRIGGERED);
    check_eq("both_value", {4'd0, value}, 8'd8);
    tick();

    // Ignition during TRIGGERED disarms.
    ignition = 1;
    tick();
    check_eq("ign_state", {5'd0, state_dbg}, ST_DISARMED);
    tick();
    check_eq("ign_siren", {7'd0, siren}, 8'd0);
    check_eq("ign_led", {7'd0, status_led}, 8'd0);
    check_eq("ign_start", {7'd0, start_timer}, 8'd0);
`ifdef FUEL_PUMP_LOCK_EN
    check_eq("pump_ign_only", {7'd0, fuel_pump}, 8'd0);
`else
    check_eq("pump_ign_only", {7'd0, fuel_pump}, 8'd1);
`endif
    hidden_sw = 1;
    brake = 1;
    tick();
    hidden_sw = 0;
    brake = 0;
    check_eq("pump_unlock", {7'd0, fuel_pump}, 8'd1);
    tick();
    check_eq("pump_stays", {7'd0, fuel_pump}, 8'd1);
    ignition = 0;
    tick();
    check_eq("pump_ign_off", {7'd0, fuel_pump}, 8'd0);
    check_eq("ign_off_wait_open", {5'd0, state_dbg}, ST_WAIT_OPEN);

    // Reprogram arm delay to 3, then walk the arming sequence.
    reprogram = 1;
    time_param_sel = 2'b00;
    time_value = 4'd3;
    tick();
    reprogram = 0;
    check_eq("reprog_state", {5'd0, state_dbg}, ST_ARMED);
    check_eq("reprog_value", {4'd0, value}, 8'd3);
    ignition = 1;
    tick();
    check_eq("seq_disarmed", {5'd0, state_dbg}, ST_DISARMED);
    ignition = 0;
    tick();
    check_eq("seq_wait_open", {5'd0, state_dbg}, ST_WAIT_OPEN);
    door_driver = 1;
    tick();
    check_eq("seq_wait_close", {5'd0, state_dbg}, ST_WAIT_CLOSE);
    tick();
    check_eq("seq_wait_close_held", {5'd0, state_dbg}, ST_WAIT_CLOSE);
    door_driver = 0;
    tick();
    check_eq("seq_arm_delay", {5'd0, state_dbg}, ST_ARM_DELAY);
    check_eq("seq_arm_value", {4'd0, value}, 8'd3);

    // Expiry held from entry: ignored while start is low and on its first cycle.
    expired = 1;
    tick();
    check_eq("exp_ignored_low", {5'd0, state_dbg}, ST_ARM_DELAY);
    tick();
    check_eq("exp_ignored_first", {5'd0, state_dbg}, ST_ARM_DELAY);
    check_eq("exp_start_high", {7'd0, start_timer}, 8'd1);
    tick();
    expired = 0;
    check_eq("exp_armed", {5'd0, state_dbg}, ST_ARMED);

    // Armed blink follows the 2 Hz enable.
    tick();
    check_eq("blink_0", {7'd0, status_led}, 8'd0);
    two_hz_enable = 1;
    tick();
    two_hz_enable = 0;
    check_eq("blink_1", {7'd0, status_led}, 8'd1);
    tick();
    check_eq("blink_hold", {7'd0, status_led}, 8'd1);
    two_hz_enable = 1;
    tick();
    two_hz_enable = 0;
    check_eq("blink_2", {7'd0, status_led}, 8'd0);

    // Ignition beats reprogram in the same cycle.
    ignition = 1;
    reprogram = 1;
    time_param_sel = 2'b10;
    time_value = 4'd5;
    tick();
    reprogram = 0;
    ignition = 0;
    check_eq("ign_over_reprog", {5'd0, state_dbg}, ST_DISARMED);

    $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_failures);
    $finish;
  end

endmodule
